// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and instruction fetch front end
// REQ -> WAIT -> HOLD fetch loop; next PC resolved from Jump/PCSrc at accept.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   Mem_Rd_Req,
  output logic [ADDR_WIDTH-1:0]  Mem_Addr,
  input  logic                   Mem_Rd_Valid,
  input  logic [INSTR_WIDTH-1:0] Mem_Rd_Data,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [5:0]             OpCode,
  output logic [5:0]             Funct,
  output logic                   Instr_Valid,
  input  logic                   Instr_Ready,
  input  logic                   PCSrc,
  input  logic                   Jump,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic [ADDR_WIDTH-1:0]  PCPlus4,
  output logic [COUNT_WIDTH-1:0] Instr_Count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    capture;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   jump_target;
  logic [ADDR_WIDTH-1:0]   branch_offset;
  logic [ADDR_WIDTH-1:0]   next_pc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (Mem_Rd_Valid) state_nxt = S_HOLD;
      S_HOLD:  if (Instr_Ready) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Request is gated by RST so nothing reaches memory while reset is held.
  always_comb begin
    Mem_Rd_Req = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      S_REQ:   Mem_Rd_Req = ~RST;
      S_WAIT:  capture    = Mem_Rd_Valid;
      S_HOLD:  accept     = Instr_Ready;
      default: Mem_Rd_Req = 1'b0;
    endcase
  end

  assign Mem_Addr = PC;
  assign PCPlus4  = PC + ADDR_WIDTH'(4);
  assign OpCode   = Instr[31:26];
  assign Funct    = Instr[5:0];

  assign jump_target   = {PCPlus4[ADDR_WIDTH-1:ADDR_WIDTH-4], Instr[25:0], 2'b00};
  assign branch_offset = {{(ADDR_WIDTH-18){Instr[15]}}, Instr[15:0], 2'b00};

  always_comb begin
    next_pc = PCPlus4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (PCSrc) begin
      next_pc = PCPlus4 + branch_offset;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC          <= RESET_PC;
      Instr       <= '0;
      Instr_Valid <= 1'b0;
      Instr_Count <= '0;
    end else begin
      if (capture) begin
        Instr       <= Mem_Rd_Data;
        Instr_Valid <= 1'b1;
      end
      if (accept) begin
        PC          <= next_pc;
        Instr_Valid <= 1'b0;
        Instr_Count <= Instr_Count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Mem_Rd_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd_Valid = 1'b0;
  logic [31:0] Mem_Rd_Data = '0;
  logic [31:0] Instr;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        Instr_Valid;
  logic        Instr_Ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] Instr_Count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_cnt = '0;

  always #5 CLK = ~CLK;

  instr_fetch_unit dut (
    .CLK(CLK), .RST(RST),
    .Mem_Rd_Req(Mem_Rd_Req), .Mem_Addr(Mem_Addr),
    .Mem_Rd_Valid(Mem_Rd_Valid), .Mem_Rd_Data(Mem_Rd_Data),
    .Instr(Instr), .OpCode(OpCode), .Funct(Funct),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .PCSrc(PCSrc), .Jump(Jump),
    .PC(PC), .PCPlus4(PCPlus4), .Instr_Count(Instr_Count)
  );

  function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                                input logic br, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(ins[15:0]));
    if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    Mem_Rd_Valid = 1'b0;
    Instr_Ready = 1'b0;
    #1;
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL rst_pc act=%h exp=%h", PC, 32'h0); end
    vectors++; if (Instr_Valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid act=%b exp=0", Instr_Valid); end
    vectors++; if (Instr_Count !== 32'h0) begin miscompares++; $display("FAIL rst_count act=%h exp=0", Instr_Count); end
    vectors++; if (Instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr act=%h exp=0", Instr); end
    vectors++; if (Mem_Rd_Req !== 1'b0) begin miscompares++; $display("FAIL rst_req act=%b exp=0", Mem_Rd_Req); end
    @(negedge CLK);
    vectors++; if (Mem_Rd_Req !== 1'b0) begin miscompares++; $display("FAIL rst_req_held act=%b exp=0", Mem_Rd_Req); end
    RST = 1'b0;
    #1;
    exp_pc  = 32'h0;
    exp_cnt = 32'h0;
  endtask

  // One full fetch: REQ cycle, lat WAIT cycles (valid on the last), stall+1 HOLD cycles.
  task automatic fetch_one(input logic [31:0] ins, input int lat, input int stall,
                           input logic br, input logic jp);
    vectors++; if (Mem_Rd_Req !== 1'b1) begin miscompares++; $display("FAIL req_pulse act=%b exp=1", Mem_Rd_Req); end
    vectors++; if (Mem_Addr !== exp_pc) begin miscompares++; $display("FAIL req_addr act=%h exp=%h", Mem_Addr, exp_pc); end
    vectors++; if (Instr_Valid !== 1'b0) begin miscompares++; $display("FAIL req_valid act=%b exp=0", Instr_Valid); end
    Mem_Rd_Valid = 1'($urandom_range(0, 1));
    Mem_Rd_Data  = $urandom;
    Instr_Ready  = 1'($urandom_range(0, 1));
    @(negedge CLK);
    for (int i = 1; i <= lat; i++) begin
      vectors++; if (Mem_Rd_Req !== 1'b0) begin miscompares++; $display("FAIL wait_req act=%b exp=0", Mem_Rd_Req); end
      vectors++; if (Instr_Valid !== 1'b0) begin miscompares++; $display("FAIL wait_valid act=%b exp=0", Instr_Valid); end
      Mem_Rd_Valid = (i == lat);
      Mem_Rd_Data  = (i == lat) ? ins : $urandom;
      Instr_Ready  = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    for (int s = 0; s <= stall; s++) begin
      vectors++; if (Instr_Valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid act=%b exp=1", Instr_Valid); end
      vectors++; if (Instr !== ins) begin miscompares++; $display("FAIL hold_instr act=%h exp=%h", Instr, ins); end
      vectors++; if (OpCode !== ins[31:26]) begin miscompares++; $display("FAIL hold_opcode act=%h exp=%h", OpCode, ins[31:26]); end
      vectors++; if (Funct !== ins[5:0]) begin miscompares++; $display("FAIL hold_funct act=%h exp=%h", Funct, ins[5:0]); end
      vectors++; if (PC !== exp_pc) begin miscompares++; $display("FAIL hold_pc act=%h exp=%h", PC, exp_pc); end
      vectors++; if (PCPlus4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL hold_pcplus4 act=%h exp=%h", PCPlus4, exp_pc + 32'd4); end
      vectors++; if (Mem_Rd_Req !== 1'b0) begin miscompares++; $display("FAIL hold_req act=%b exp=0", Mem_Rd_Req); end
      Mem_Rd_Valid = 1'($urandom_range(0, 1));
      Mem_Rd_Data  = $urandom;
      Instr_Ready  = (s == stall);
      PCSrc        = (s == stall) ? br : 1'($urandom_range(0, 1));
      Jump         = (s == stall) ? jp : 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    exp_pc  = model_next_pc(exp_pc, ins, br, jp);
    exp_cnt = exp_cnt + 32'd1;
    Instr_Ready  = 1'b0;
    Mem_Rd_Valid = 1'b0;
    vectors++; if (PC !== exp_pc) begin miscompares++; $display("FAIL accept_pc act=%h exp=%h", PC, exp_pc); end
    vectors++; if (Instr_Count !== exp_cnt) begin miscompares++; $display("FAIL accept_count act=%h exp=%h", Instr_Count, exp_cnt); end
    vectors++; if (Instr_Valid !== 1'b0) begin miscompares++; $display("FAIL accept_valid act=%b exp=0", Instr_Valid); end
    vectors++; if (Instr !== ins) begin miscompares++; $display("FAIL accept_instr_kept act=%h exp=%h", Instr, ins); end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (Mem_Rd_Req !== 1'b1) begin miscompares++; $display("FAIL reset_first_req act=%b exp=1", Mem_Rd_Req); end
    vectors++; if (Mem_Addr !== 32'h0) begin miscompares++; $display("FAIL reset_first_addr act=%h exp=0", Mem_Addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 3; k++) fetch_one(32'h2008_0005, 1, 0, 1'b0, 1'b0);
    vectors++; if (Instr_Count !== 32'd3) begin miscompares++; $display("FAIL seq_count act=%0d exp=3", Instr_Count); end
    vectors++; if (PC !== 32'hC) begin miscompares++; $display("FAIL seq_pc act=%h exp=c", PC); end
  endtask

  task automatic test_branch();
    do_reset();
    for (int k = 0; k < 4; k++) fetch_one(32'h0000_0020, 1, 0, 1'b0, 1'b0);
    fetch_one(32'h1000_0003, 2, 0, 1'b1, 1'b0);
    vectors++; if (PC !== 32'h20) begin miscompares++; $display("FAIL branch_fwd act=%h exp=20", PC); end
    do_reset();
    for (int k = 0; k < 4; k++) fetch_one(32'h0000_0020, 1, 0, 1'b0, 1'b0);
    fetch_one(32'h1000_FFFF, 1, 1, 1'b1, 1'b0);
    vectors++; if (PC !== 32'h10) begin miscompares++; $display("FAIL branch_back act=%h exp=10", PC); end
  endtask

  task automatic test_jump_priority();
    do_reset();
    fetch_one(32'h0800_000C, 1, 0, 1'b0, 1'b1);
    vectors++; if (PC !== 32'h30) begin miscompares++; $display("FAIL jump_setup act=%h exp=30", PC); end
    fetch_one(32'h0800_0040, 1, 0, 1'b1, 1'b1);
    vectors++; if (PC !== 32'h100) begin miscompares++; $display("FAIL jump_priority act=%h exp=100", PC); end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_one(32'h2008_0005, 1, 0, 1'b0, 1'b0);
    fetch_one(32'h0123_4567, 5, 3, 1'b0, 1'b0);
    vectors++; if (PC !== 32'h8) begin miscompares++; $display("FAIL stall_pc act=%h exp=8", PC); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int k = 0; k < 6; k++) fetch_one(32'h0000_0020, 1, 0, 1'b0, 1'b0);
    fetch_one(32'h0800_0010, 1, 0, 1'b0, 1'b1);
    vectors++; if (PC !== 32'h40) begin miscompares++; $display("FAIL midwait_setup_pc act=%h exp=40", PC); end
    vectors++; if (Instr_Count !== 32'd7) begin miscompares++; $display("FAIL midwait_setup_cnt act=%0d exp=7", Instr_Count); end
    Mem_Rd_Valid = 1'b0;
    @(negedge CLK);
    vectors++; if (Mem_Rd_Req !== 1'b0) begin miscompares++; $display("FAIL midwait_in_wait act=%b exp=0", Mem_Rd_Req); end
    do_reset();
    vectors++; if (Mem_Addr !== 32'h0) begin miscompares++; $display("FAIL midwait_restart_addr act=%h exp=0", Mem_Addr); end
    fetch_one(32'h2008_0005, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      ins = $urandom;
      fetch_one(ins, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
